// File: rtl/hog_frame_sequencer.sv
// hog_frame_sequencer: frame-level controller for the scaling/HOG datapath.
// Scatters a raster pixel stream 2x2-interleaved into four image banks,
// kicks the scaler, waits for scaling and feature-write completion, and
// reports frame completion or a wait timeout.
module hog_frame_sequencer #(
   parameter int unsigned RAM_AW  = 17,
   parameter int unsigned P_WIDTH = 8,
   parameter int unsigned IMGX    = 136,
   parameter int unsigned IMGY    = 136,
   parameter int unsigned TIMEOUT = 24'hFF_FFFF
) (
   input  logic               aclk,
   input  logic               arest_n,
   input  logic               frame_go,
   input  logic               sw_abort,
   input  logic               pix_valid,
   input  logic [P_WIDTH-1:0] pix_data,
   output logic               pix_ready,
   input  logic               res_busy,
   output logic [3:0]         init_ena,
   output logic [RAM_AW-1:0]  init_addra,
   output logic [P_WIDTH-1:0] init_dina,
   output logic               start,
   input  logic               scaling_finish,
   input  logic               write_feature_done,
   output logic               frame_done,
   output logic               busy,
   output logic               timeout_err,
   output logic [2:0]         state_o
);

   localparam int unsigned CW    = (IMGX > 1) ? $clog2(IMGX) : 1;
   localparam int unsigned RW    = (IMGY > 1) ? $clog2(IMGY) : 1;
   localparam int unsigned WW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned HALFX = IMGX / 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_SCALE = 3'd3,
      S_HOG   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               state, state_d;
   logic [CW-1:0]        col, col_d;
   logic [RW-1:0]        row, row_d;
   logic [WW-1:0]        wait_cnt, wait_d;
   logic                 wfd_seen, wfd_seen_d;
   logic                 timeout_d, start_d, done_d;
   logic [3:0]           ena_d;
   logic [RAM_AW-1:0]    addr_d;
   logic [P_WIDTH-1:0]   din_d;

   logic                 accept_c;
   logic                 last_col_c;
   logic                 last_pix_c;
   logic                 wait_expired_c;
   logic [1:0]           bank_c;
   logic [31:0]          addr_full_c;

   // Pixel acceptance and bank/address decode for the current raster position
   assign pix_ready      = (state == S_LOAD) && !res_busy;
   assign accept_c       = pix_valid && pix_ready;
   assign last_col_c     = (col == CW'(IMGX - 1));
   assign last_pix_c     = last_col_c && (row == RW'(IMGY - 1));
   assign bank_c         = {row[0], col[0]};
   assign addr_full_c    = 32'(row >> 1) * 32'(HALFX) + 32'(col >> 1);
   assign wait_expired_c = (wait_cnt == WW'(TIMEOUT - 1));

   assign busy    = (state != S_IDLE);
   assign state_o = state;

   // Next-state and next-output logic; abort overrides every transition
   always_comb begin
      state_d     = state;
      col_d       = col;
      row_d       = row;
      wait_d      = wait_cnt;
      wfd_seen_d  = wfd_seen;
      timeout_d   = timeout_err;
      start_d     = 1'b0;
      done_d      = 1'b0;
      ena_d       = 4'b0000;
      addr_d      = init_addra;
      din_d       = init_dina;

      case (state)
         S_IDLE: begin
            if (frame_go) begin
               col_d     = '0;
               row_d     = '0;
               timeout_d = 1'b0;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept_c) begin
               ena_d  = 4'b0001 << bank_c;
               addr_d = RAM_AW'(addr_full_c);
               din_d  = pix_data;
               if (last_pix_c) begin
                  state_d = S_START;
               end else if (last_col_c) begin
                  col_d = '0;
                  row_d = row + RW'(1);
               end else begin
                  col_d = col + CW'(1);
               end
            end
         end
         S_START: begin
            start_d    = 1'b1;
            wait_d     = '0;
            wfd_seen_d = 1'b0;
            state_d    = S_SCALE;
         end
         S_SCALE: begin
            wait_d = wait_cnt + WW'(1);
            if (write_feature_done) begin
               wfd_seen_d = 1'b1;
            end
            if (scaling_finish) begin
               wait_d  = '0;
               state_d = S_HOG;
            end else if (wait_expired_c) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_HOG: begin
            wait_d = wait_cnt + WW'(1);
            if (write_feature_done || wfd_seen) begin
               wfd_seen_d = 1'b0;
               state_d    = S_DONE;
            end else if (wait_expired_c) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (sw_abort) begin
         state_d    = S_IDLE;
         ena_d      = 4'b0000;
         start_d    = 1'b0;
         done_d     = 1'b0;
         wfd_seen_d = 1'b0;
         timeout_d  = timeout_err;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge aclk or negedge arest_n) begin
      if (!arest_n) begin
         state       <= S_IDLE;
         col         <= '0;
         row         <= '0;
         wait_cnt    <= '0;
         wfd_seen    <= 1'b0;
         timeout_err <= 1'b0;
         start       <= 1'b0;
         frame_done  <= 1'b0;
         init_ena    <= 4'b0000;
         init_addra  <= '0;
         init_dina   <= '0;
      end else begin
         state       <= state_d;
         col         <= col_d;
         row         <= row_d;
         wait_cnt    <= wait_d;
         wfd_seen    <= wfd_seen_d;
         timeout_err <= timeout_d;
         start       <= start_d;
         frame_done  <= done_d;
         init_ena    <= ena_d;
         init_addra  <= addr_d;
         init_dina   <= din_d;
      end
   end

endmodule

// File: tb/tb_hog_frame_sequencer.sv
// Directed bench for hog_frame_sequencer on a 4x4 frame. The main instance
// uses a long wait limit; a second instance with an 8-cycle limit covers
// the timeout path.
module tb_hog_frame_sequencer;

   logic        aclk = 1'b0;
   logic        arest_n;
   logic        frame_go, go_t, sw_abort, pix_valid, res_busy;
   logic [7:0]  pix_data;
   logic        scaling_finish, write_feature_done;

   logic        pix_ready, start, frame_done, busy, timeout_err;
   logic [3:0]  init_ena;
   logic [16:0] init_addra;
   logic [7:0]  init_dina;
   logic [2:0]  state_o;

   logic        t_pix_ready, t_start, t_frame_done, t_busy, t_timeout_err;
   logic [3:0]  t_init_ena;
   logic [16:0] t_init_addra;
   logic [7:0]  t_init_dina;
   logic [2:0]  t_state_o;

   int errors = 0;
   int checks = 0;
   int writes;

   // Hand-computed bank enables and addresses for pixels 0..15 of a 4x4 frame
   int exp_ena[16]  = '{1, 2, 1, 2, 4, 8, 4, 8, 1, 2, 1, 2, 4, 8, 4, 8};
   int exp_addr[16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};

   always #5 aclk = ~aclk;

   hog_frame_sequencer #(.RAM_AW(17), .P_WIDTH(8), .IMGX(4), .IMGY(4), .TIMEOUT(64)) dut (
      .aclk(aclk), .arest_n(arest_n), .frame_go(frame_go), .sw_abort(sw_abort),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .res_busy(res_busy), .init_ena(init_ena), .init_addra(init_addra),
      .init_dina(init_dina), .start(start), .scaling_finish(scaling_finish),
      .write_feature_done(write_feature_done), .frame_done(frame_done),
      .busy(busy), .timeout_err(timeout_err), .state_o(state_o));

   hog_frame_sequencer #(.RAM_AW(17), .P_WIDTH(8), .IMGX(4), .IMGY(4), .TIMEOUT(8)) dut_t (
      .aclk(aclk), .arest_n(arest_n), .frame_go(go_t), .sw_abort(sw_abort),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(t_pix_ready),
      .res_busy(res_busy), .init_ena(t_init_ena), .init_addra(t_init_addra),
      .init_dina(t_init_dina), .start(t_start), .scaling_finish(scaling_finish),
      .write_feature_done(write_feature_done), .frame_done(t_frame_done),
      .busy(t_busy), .timeout_err(t_timeout_err), .state_o(t_state_o));

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h required=%0h", tag, obs, expv);
      end
   endtask

   // Start a frame on one instance and stream pixels 0..15 without stalls
   task automatic load_frame(input bit use_t);
      if (use_t) go_t = 1'b1; else frame_go = 1'b1;
      tick();
      go_t = 1'b0;
      frame_go = 1'b0;
      pix_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pix_data = 8'(i);
         tick();
      end
      pix_valid = 1'b0;
   endtask

   // Global guard so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      arest_n = 1'b0;
      frame_go = 1'b0; go_t = 1'b0; sw_abort = 1'b0; pix_valid = 1'b0;
      pix_data = 8'h00; res_busy = 1'b0;
      scaling_finish = 1'b0; write_feature_done = 1'b0;

      // Reset state
      #12;
      check("rst_state", 32'(state_o), 0);
      check("rst_ready", 32'(pix_ready), 0);
      check("rst_ena", 32'(init_ena), 0);
      check("rst_addr", 32'(init_addra), 0);
      check("rst_din", 32'(init_dina), 0);
      check("rst_start", 32'(start), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_terr", 32'(timeout_err), 0);
      arest_n = 1'b1;

      // Bank/address mapping over a full 4x4 frame
      frame_go = 1'b1;
      tick();
      frame_go = 1'b0;
      check("go_state", 32'(state_o), 1);
      check("go_busy", 32'(busy), 1);
      pix_valid = 1'b1;
      writes = 0;
      for (int i = 0; i < 16; i++) begin
         pix_data = 8'(i);
         check("map_ready", 32'(pix_ready), 1);
         tick();
         if (init_ena != 4'b0000) writes++;
         check($sformatf("map_ena_p%0d", i), 32'(init_ena), 32'(exp_ena[i]));
         check($sformatf("map_addr_p%0d", i), 32'(init_addra), 32'(exp_addr[i]));
         check($sformatf("map_din_p%0d", i), 32'(init_dina), 32'(i));
      end
      pix_valid = 1'b0;
      check("last_state_start", 32'(state_o), 2);
      check("last_ready", 32'(pix_ready), 0);
      tick();
      if (init_ena != 4'b0000) writes++;
      check("write_count", 32'(writes), 16);
      check("start_high", 32'(start), 1);
      check("start_state_scale", 32'(state_o), 3);
      tick();
      check("start_one_cycle", 32'(start), 0);

      // Full frame: finish 20 cycles after start, feature done 30 later
      for (int i = 0; i < 19; i++) tick();
      scaling_finish = 1'b1;
      tick();
      scaling_finish = 1'b0;
      check("full_hog", 32'(state_o), 4);
      for (int i = 0; i < 29; i++) tick();
      write_feature_done = 1'b1;
      check("full_no_early_done", 32'(frame_done), 0);
      tick();
      write_feature_done = 1'b0;
      check("full_state_done", 32'(state_o), 5);
      check("full_done_wait", 32'(frame_done), 0);
      check("full_busy_in_done", 32'(busy), 1);
      tick();
      check("full_done_pulse", 32'(frame_done), 1);
      check("full_busy_low", 32'(busy), 0);
      check("full_idle", 32'(state_o), 0);
      tick();
      check("full_done_single", 32'(frame_done), 0);
      check("full_no_terr", 32'(timeout_err), 0);

      // Back-pressure on pixel 6
      frame_go = 1'b1;
      tick();
      frame_go = 1'b0;
      pix_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pix_data = 8'(i);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         pix_data = 8'd6;
         res_busy = 1'b1;
         #1;
         check("bp_ready_low", 32'(pix_ready), 0);
         tick();
         check("bp_no_write", 32'(init_ena), 0);
      end
      res_busy = 1'b0;
      #1;
      check("bp_ready_back", 32'(pix_ready), 1);
      tick();
      check("bp_p6_ena", 32'(init_ena), 4);
      check("bp_p6_addr", 32'(init_addra), 1);
      check("bp_p6_din", 32'(init_dina), 6);

      // Abort at pixel 9 with the pixel still valid
      pix_data = 8'd7;
      tick();
      pix_data = 8'd8;
      tick();
      pix_data = 8'd9;
      sw_abort = 1'b1;
      tick();
      check("abort_state", 32'(state_o), 0);
      check("abort_ena", 32'(init_ena), 0);
      check("abort_ready", 32'(pix_ready), 0);
      check("abort_busy", 32'(busy), 0);
      sw_abort = 1'b0;
      tick();
      check("stray_valid_no_write", 32'(init_ena), 0);

      // Abort wins over a simultaneous frame_go
      frame_go = 1'b1;
      sw_abort = 1'b1;
      tick();
      sw_abort = 1'b0;
      check("abort_over_go", 32'(state_o), 0);

      // Restarted frame begins at bank0 addr0; stray frame_go in LOAD ignored
      pix_data = 8'hA5;
      tick();
      frame_go = 1'b0;
      check("restart_load", 32'(state_o), 1);
      tick();
      check("restart_ena", 32'(init_ena), 1);
      check("restart_addr", 32'(init_addra), 0);
      check("restart_din", 32'(init_dina), 32'h A5);
      pix_data = 8'h5A;
      frame_go = 1'b1;
      tick();
      frame_go = 1'b0;
      check("stray_go_ena", 32'(init_ena), 2);
      check("stray_go_addr", 32'(init_addra), 0);
      pix_valid = 1'b0;
      sw_abort = 1'b1;
      tick();
      sw_abort = 1'b0;
      check("abort2_state", 32'(state_o), 0);

      // Timeout on the 8-cycle instance: scaling_finish never arrives
      load_frame(1'b1);
      check("main_ignores_stream", 32'(init_ena), 0);
      check("t_start_state", 32'(t_state_o), 2);
      tick();
      check("t_start", 32'(t_start), 1);
      check("t_scale", 32'(t_state_o), 3);
      for (int i = 0; i < 7; i++) tick();
      check("t_scale_8th", 32'(t_state_o), 3);
      check("t_no_err_yet", 32'(t_timeout_err), 0);
      tick();
      check("t_idle", 32'(t_state_o), 0);
      check("t_err_set", 32'(t_timeout_err), 1);
      check("t_no_done", 32'(t_frame_done), 0);
      check("t_busy_low", 32'(t_busy), 0);
      tick();
      check("t_no_done_late", 32'(t_frame_done), 0);
      check("t_err_sticky", 32'(t_timeout_err), 1);
      go_t = 1'b1;
      tick();
      go_t = 1'b0;
      check("t_err_cleared", 32'(t_timeout_err), 0);
      check("t_reload", 32'(t_state_o), 1);
      sw_abort = 1'b1;
      tick();
      sw_abort = 1'b0;

      // Simultaneous scaling_finish and write_feature_done:
      // event cycle, then HOG, then DONE, then the frame_done pulse
      load_frame(1'b0);
      tick();
      check("sim_start", 32'(start), 1);
      tick();
      tick();
      scaling_finish = 1'b1;
      write_feature_done = 1'b1;
      tick();
      scaling_finish = 1'b0;
      write_feature_done = 1'b0;
      check("sim_hog", 32'(state_o), 4);
      tick();
      check("sim_done_state", 32'(state_o), 5);
      check("sim_done_wait", 32'(frame_done), 0);
      tick();
      check("sim_done_pulse", 32'(frame_done), 1);
      check("sim_no_terr", 32'(timeout_err), 0);
      check("sim_idle", 32'(state_o), 0);

      // Asynchronous reset mid-SCALE clears outputs without a clock edge
      load_frame(1'b0);
      tick();
      tick();
      tick();
      check("ar_in_scale", 32'(state_o), 3);
      check("ar_din_before", 32'(init_dina), 15);
      #3;
      arest_n = 1'b0;
      #1;
      check("ar_state", 32'(state_o), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_ready", 32'(pix_ready), 0);
      check("ar_ena", 32'(init_ena), 0);
      check("ar_addr", 32'(init_addra), 0);
      check("ar_din", 32'(init_dina), 0);
      check("ar_start", 32'(start), 0);
      check("ar_done", 32'(frame_done), 0);
      check("ar_terr", 32'(timeout_err), 0);
      #2;
      arest_n = 1'b1;
      tick();
      check("ar_stays_idle", 32'(state_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hog_frame_sequencer.md
# hog_frame_sequencer

Frame-level controller for the image-scaling/HOG datapath. It accepts a raster pixel stream and scatters it 2×2-interleaved into the four shared image banks through their initial-write port. It then pulses the scaler `start` and waits for `scaling_finish` and `write_feature_done`. It signals frame completion, and reports a timeout if either wait stalls.

## Interface
Parameters:
- `RAM_AW`, 17, bank address width
- `P_WIDTH`, 8, pixel width
- `IMGX`, 136, frame width in pixels (even)
- `IMGY`, 136, frame height in pixels (even)
- `TIMEOUT`, 2^24-1, maximum cycles allowed in each wait state

Ports:
- `aclk`  in  1  clock
- `arest_n`  in  1  reset, asynchronous, active-low; all state is cleared on assertion
- `frame_go`  in  1  one-cycle request to begin a frame; ignored unless in IDLE
- `sw_abort`  in  1  return to IDLE from any state
- `pix_valid`  in  1  pixel stream valid
- `pix_data`  in  P_WIDTH  pixel value
- `pix_ready`  out  1  pixel stream ready
- `res_busy`  in  1  OR of the four result-write enables from the HOG side
- `init_ena`  out  4  one-hot bank write enable (also used as wea)
- `init_addra`  out  RAM_AW  bank write address
- `init_dina`  out  P_WIDTH  bank write data
- `start`  out  1  one-cycle scaler start
- `scaling_finish`  in  1  scaler done pulse
- `write_feature_done`  in  1  HOG feature write done pulse
- `frame_done`  out  1  one-cycle completion pulse
- `busy`  out  1  high when not in IDLE
- `timeout_err`  out  1  sticky error flag; cleared by `frame_go` or reset
- `state_o`  out  3  current state encoding

## Operation
- States, with `state_o` encoding: IDLE=0, LOAD=1, START=2, SCALE=3, HOG=4, DONE=5.
- **IDLE**
  - On `frame_go`: clear the col/row counters and `timeout_err`, then go to LOAD.
- **LOAD**
  - `pix_ready` = (state==LOAD) && !`res_busy`. This is combinational.
  - A pixel is accepted when `pix_valid` && `pix_ready`.
  - The accepted pixel is written to bank b = {row[0], col[0]}: row0/col0 → 0, row0/col1 → 1, row1/col0 → 2, row1/col1 → 3.
  - Write address = (row>>1)*(IMGX/2) + (col>>1). It is computed modulo 2^RAM_AW; no overflow check is made.
  - `col` wraps at IMGX-1 and increments `row`.
  - Acceptance of pixel (IMGX-1, IMGY-1) moves the FSM to START.
- **START**
  - Assert `start` for exactly one cycle, then go to SCALE.
- **SCALE**
  - Wait for `scaling_finish`, then go to HOG.
  - A `write_feature_done` seen while in SCALE is latched; HOG then exits on its next cycle.
- **HOG**
  - Wait for `write_feature_done` or the latched event, then go to DONE.
- **DONE**
  - Assert `frame_done` for one cycle, then go to IDLE.
- **Timeout**
  - A wait counter resets on entry to SCALE and HOG and increments every cycle in those states.
  - When it reaches TIMEOUT: set `timeout_err` and go to IDLE. No `frame_done` is issued.
- **Abort**
  - `sw_abort` forces IDLE from any state, on the next edge.
  - It deasserts `init_ena` on that same edge; a partially loaded frame is discarded.
  - `sw_abort` takes priority over every other transition, including `frame_go` in the same cycle.

## Timing
- **Reset values:** state=IDLE, `pix_ready`=0, `init_ena`=0, `init_addra`=0, `init_dina`=0, `start`=0, `frame_done`=0, `busy`=0, `timeout_err`=0.
- **Bank write outputs** are registered. A pixel accepted at edge k drives `init_ena`/`init_addra`/`init_dina` for the single cycle following edge k. `init_ena` is 0 in every cycle without an acceptance.
- **Start latency:** `start` rises one cycle after the last pixel's write cycle, i.e. at edge k+1 after final acceptance edge k. The last write is therefore already in the BRAM before `start`.
- **Done latency:** `frame_done` goes high the cycle after HOG exits. `busy` falls together with the DONE→IDLE transition.
- **Back-pressure:** if `res_busy` rises mid-LOAD, `pix_ready` drops in the same cycle and no write is issued. The counters hold until `res_busy` falls.
- **Stray inputs:** `frame_go` outside IDLE and `pix_valid` outside LOAD are ignored.
- **Simultaneous finish/done in SCALE:** if `scaling_finish` and `write_feature_done` arrive in the same cycle, the FSM goes SCALE→HOG→DONE, one cycle per state.

## Test plan
- **Bank/address mapping.** IMGX=IMGY=4, stream pixels 0..15 with data = index, valid always high. Required writes:
  - p0 → bank0 addr0
  - p1 → bank1 addr0
  - p2 → bank0 addr1
  - p4 → bank2 addr0
  - p5 → bank3 addr0
  - p10 → bank0 addr3
  - p15 → bank3 addr3

  Exactly 16 write cycles occur, and `start` is high the cycle after p15's write.
- **Back-pressure.** Hold `res_busy`=1 for 3 cycles during pixel 6. Required: `pix_ready`=0 for those 3 cycles, no `init_ena` pulses, and pixel 6 is written to bank2 addr1 after release.
- **Full frame.** Pulse `scaling_finish` 20 cycles after `start` and `write_feature_done` 30 cycles later. Required: `frame_done` is a single pulse 2 cycles after `write_feature_done` (HOG→DONE, then DONE asserting), followed by `busy`=0.
- **Timeout.** TIMEOUT=8, never pulse `scaling_finish`. Required: `timeout_err`=1 after 8 SCALE cycles, state=IDLE, no `frame_done`; the next `frame_go` clears `timeout_err`.
- **Abort and async reset.**
  - `sw_abort` at pixel 9: state=0 on the next edge, `init_ena`=0, `pix_ready`=0.
  - A subsequent frame restarts at bank0 addr0.
  - Asserting `arest_n`=0 mid-SCALE clears all outputs immediately, without waiting for a clock edge.
- **Simultaneous events.** `scaling_finish` and `write_feature_done` in the same cycle. Required: `frame_done` 2 cycles later, and no timeout.
